// File: rtl/cla_pkg.sv
// Shared types and constants for the CLA-based restoring divider and its
// carry-lookahead subtractor.
package cla_pkg;

  localparam int DIV_WIDTH = 16;
  // Iteration counter must be able to hold WIDTH-1 with headroom.
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_sub.sv
// Combinational N-bit subtractor x - y computed as x + ~y + 1 with 4-bit
// lookahead groups; borrow is the inverted carry-out.
module cla_sub #(
  parameter int N = 17
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  int           base;
  logic         acc_g;
  logic         acc_p;

  assign g = x & ~y;
  assign p = x ^ ~y;

  // Each bit's carry is a flat generate/propagate product back to its group's
  // carry-in; group carries chain from one 4-bit block to the next.
  always_comb begin
    c     = '0;
    c[0]  = 1'b1;
    base  = 0;
    acc_g = 1'b0;
    acc_p = 1'b0;
    for (int i = 0; i < N; i++) begin
      base  = (i / 4) * 4;
      acc_g = g[i];
      acc_p = p[i];
      for (int k = 1; k < 4; k++) begin
        if (i - k >= base) begin
          acc_g = acc_g | (acc_p & g[i-k]);
          acc_p = acc_p & p[i-k];
        end
      end
      c[i+1] = acc_g | (acc_p & c[base]);
    end
  end

  assign diff   = p ^ c[N-1:0];
  assign borrow = ~c[N];

endmodule

// File: rtl/cla_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional divide-by-zero fast path and dbz flag: CLA_DIV_DBZ_EN.
module cla_restoring_divider
  import cla_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
`ifdef CLA_DIV_DBZ_EN
  output logic             dbz,
`endif
  output state_e           dbg_state
);

  // Handshake: start is sampled only on an edge where busy=0; operands are
  // captured on that edge. busy stays high until the single-cycle done pulse,
  // and quotient/remainder then hold until a later result overwrites them.

  state_e           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
`ifdef CLA_DIV_DBZ_EN
  logic             dbz_q, dbz_d;
`endif

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             last_step;
  logic             div_zero;
  logic             unused_a_msb;

  assign t         = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  // A stays below the divisor between steps, so its top bit is never needed.
  assign unused_a_msb = a_q[WIDTH];

`ifdef CLA_DIV_DBZ_EN
  assign div_zero = (divisor == '0);
`else
  assign div_zero = 1'b0;
`endif

  cla_sub #(.N(WIDTH + 1)) u_sub (
    .x      (t),
    .y      ({1'b0, d_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef CLA_DIV_DBZ_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef CLA_DIV_DBZ_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = div_zero ? DONE : RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
`ifdef CLA_DIV_DBZ_EN
    dbz_d = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = '0;
          q_d   = dividend;
          d_d   = divisor;
          cnt_d = '0;
`ifdef CLA_DIV_DBZ_EN
          dbz_d = 1'b0;
          if (div_zero) begin
            quo_d = '1;
            rem_d = dividend;
            dbz_d = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        a_d   = borrow ? t : diff;
        q_d   = {q_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          quo_d = q_d;
          rem_d = a_d[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    dbg_state = state_q;
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef CLA_DIV_DBZ_EN
  assign dbz       = dbz_q;
`endif

endmodule

// File: tb/tb_cla_restoring_divider.sv
// Self-checking bench for cla_restoring_divider: arithmetic reference model,
// per-cycle compare of busy/done/results, directed cases and a random stream.
module tb_cla_restoring_divider;
  import cla_pkg::*;

  localparam int W      = 16;
  localparam int N_RAND = 2000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
`ifdef CLA_DIV_DBZ_EN
  logic         dbz;
`endif
  state_e       dbg_state;

  cla_restoring_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
`ifdef CLA_DIV_DBZ_EN
    .dbz       (dbz),
`endif
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain division, plus accept/done timing in edge counts.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    logic z;
`ifdef CLA_DIV_DBZ_EN
    z = 1'b1;
`else
    z = 1'b0;
`endif
    if (b == '0) return {z, {W{1'b1}}, a};
    return {1'b0, a / b, a % b};
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b);
`ifdef CLA_DIV_DBZ_EN
    if (b == '0) return 0;
`endif
    return W;
  endfunction

  logic [2*W:0] exp_q[$];
  int           exp_cyc_q[$];
  int           cyc;
  int           free_at;
  int           last_acc;
  int           last_l;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc      <= 0;
      free_at  <= 0;
      last_acc <= -100;
      last_l   <= 0;
      exp_q.delete();
      exp_cyc_q.delete();
    end else begin
      cyc <= cyc + 1;
      if (start && (cyc + 1) >= free_at) begin
        exp_q.push_back(ref_div(dividend, divisor));
        exp_cyc_q.push_back(cyc + 1 + ref_lat(divisor));
        free_at  <= cyc + 1 + ref_lat(divisor) + 2;
        last_acc <= cyc + 1;
        last_l   <= ref_lat(divisor);
      end
    end
  end

  logic [W-1:0] hq = '0;
  logic [W-1:0] hr = '0;
  bit           rand_mode = 1'b0;
  int           prev_done = -1;

  task automatic compare_cycle();
    logic         exp_done;
    logic         exp_busy;
    logic [2*W:0] e;
    if (!rst_n) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
`ifdef CLA_DIV_DBZ_EN
      check("rst_dbz", dbz, 0);
`endif
      hq = '0;
      hr = '0;
      prev_done = -1;
      return;
    end
    exp_done = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
    exp_busy = (cyc >= last_acc) && (cyc <= last_acc + last_l);
    check("done", done, exp_done);
    check("busy", busy, exp_busy);
    if (exp_done) begin
      e = exp_q.pop_front();
      void'(exp_cyc_q.pop_front());
      check("quotient", quotient, e[2*W-1:W]);
      check("remainder", remainder, e[W-1:0]);
`ifdef CLA_DIV_DBZ_EN
      check("dbz", dbz, e[2*W]);
`endif
      hq = e[2*W-1:W];
      hr = e[W-1:0];
      if (rand_mode && prev_done >= 0) check("done_spacing", cyc - prev_done, W + 2);
      prev_done = rand_mode ? cyc : -1;
    end else if (!exp_busy) begin
      check("hold_quotient", quotient, hq);
      check("hold_remainder", remainder, hr);
    end
  endtask

  always @(negedge clk) compare_cycle();

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input int elat, input logic edbz);
    int n;
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!done && n < 40);
    check("op_done_seen", done, 1);
    check("op_latency", n, elat);
    check("op_quotient", quotient, eq);
    check("op_remainder", remainder, er);
`ifdef CLA_DIV_DBZ_EN
    check("op_dbz", dbz, edbz);
`else
    if (edbz) check("op_dbz_unexpected", edbz, 0);
`endif
    @(negedge clk);
    check("op_busy_after", busy, 0);
  endtask

  function automatic logic [W-1:0] rand_divisor();
    case ($urandom_range(0, 3))
      0:       return W'($urandom_range(1, 15));
      1:       return W'($urandom_range(1, 255));
      default: return W'($urandom_range(1, 65535));
    endcase
  endfunction

  initial begin
    int n;
    int ndone;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("init_busy", busy, 0);
    check("init_quotient", quotient, 0);
    check("init_state", dbg_state, IDLE);

    run_op(16'd100, 16'd7, 16'd14, 16'd2, W + 1, 1'b0);

    // Re-pulse start during RUN and on the DONE cycle; both must be ignored.
    @(negedge clk);
    start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; dividend = 16'd9; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ign_done_seen", done, 1);
    check("ign_quotient", quotient, 14);
    check("ign_remainder", remainder, 2);
    start = 1'b1; dividend = 16'd9; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ign_extra_done", ndone, 0);
    check("ign_quotient_kept", quotient, 14);

    run_op(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, W + 1, 1'b0);
    run_op(16'd5, 16'd9, 16'd0, 16'd5, W + 1, 1'b0);
    run_op(16'h8000, 16'h8000, 16'h0001, 16'h0000, W + 1, 1'b0);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    start = 1'b1; dividend = 16'h1234; divisor = 16'h0011;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_quotient", quotient, 0);
    check("arst_remainder", remainder, 0);
    check("arst_state", dbg_state, IDLE);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(16'h1234, 16'h0011, 16'h0112, 16'h0002, W + 1, 1'b0);

`ifdef CLA_DIV_DBZ_EN
    run_op(16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1, 1'b1);
`else
    run_op(16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, W + 1, 1'b0);
`endif
    run_op(16'd100, 16'd7, 16'd14, 16'd2, W + 1, 1'b0);

    // Random stream with start held high; operands change every cycle.
    @(negedge clk);
    rand_mode = 1'b1;
    start = 1'b1;
    repeat (N_RAND * (W + 2)) begin
      dividend = W'($urandom);
      divisor = rand_divisor();
      @(negedge clk);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);
    rand_mode = 1'b0;
    check("drain_empty", exp_cyc_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
